// File: rtl/stack_guard.sv
// rtl/stack_guard.sv - push/pop sequencer guarding a 12-entry operand stack (optional STACK_GUARD_WATERMARK_EN)

`ifndef OP_PUSH_R
`define OP_PUSH_R 4'h1
`endif
`ifndef OP_POP_R
`define OP_POP_R 4'h2
`endif

module stack_guard #(
    parameter int          DATA_W  = 14,
    parameter int          VOLUME  = 12,
    parameter int          DEPTH_W = 4,
    parameter logic [3:0]  NOP_OP  = 4'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_opcode,
    input  logic [DATA_W-1:0]  req_data,
    output logic [3:0]         stk_opcode,
    output logic [DATA_W-1:0]  stk_push,
    input  logic [DATA_W-1:0]  stk_pop,
    output logic               stk_reset,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic               ovf_err,
    output logic               unf_err,
`ifdef STACK_GUARD_WATERMARK_EN
    output logic [DEPTH_W-1:0] max_depth,
`endif
    input  logic               err_clr
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        POP_ISSUE   = 2'd1,
        POP_CAPTURE = 2'd2
    } state_t;

    localparam logic [DEPTH_W-1:0] VOL_D = DEPTH_W'(VOLUME);
    localparam logic [DEPTH_W-1:0] ONE_D = DEPTH_W'(1);

    state_t             state;
    logic               accept;
    logic               is_push;
    logic               is_pop;
    logic               do_push;
    logic               do_pop;
    logic               ovf_hit;
    logic               unf_hit;
    logic [DEPTH_W-1:0] depth_next;

    assign full      = (depth == VOL_D);
    assign empty     = (depth == '0);
    // Requests are only taken while idle and once the stack has left reset.
    assign req_ready = (state == IDLE) && !stk_reset;

    // Classify the incoming request and compute the depth after this edge.
    always_comb begin
        accept     = req_valid && req_ready;
        is_push    = accept && (req_opcode == `OP_PUSH_R);
        is_pop     = accept && (req_opcode == `OP_POP_R);
        do_push    = is_push && !full;
        do_pop     = is_pop && !empty;
        ovf_hit    = is_push && full;
        unf_hit    = is_pop && empty;
        depth_next = depth;
        if (do_push) begin
            depth_next = depth + ONE_D;
        end else if (do_pop) begin
            depth_next = depth - ONE_D;
        end
    end

    // Sequencer: forwards legal ops, runs the three-edge pop handshake, tracks depth and error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            depth      <= '0;
            stk_opcode <= NOP_OP;
            stk_push   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            ovf_err    <= 1'b0;
            unf_err    <= 1'b0;
            stk_reset  <= 1'b1;
        end else begin
            stk_reset  <= 1'b0;
            stk_opcode <= NOP_OP;
            rd_valid   <= 1'b0;
            depth      <= depth_next;
            if (err_clr) begin
                ovf_err <= 1'b0;
                unf_err <= 1'b0;
            end
            if (ovf_hit) begin
                ovf_err <= 1'b1;
            end
            if (unf_hit) begin
                unf_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (do_push) begin
                        stk_opcode <= `OP_PUSH_R;
                        stk_push   <= req_data;
                    end else if (do_pop) begin
                        stk_opcode <= `OP_POP_R;
                        state      <= POP_ISSUE;
                    end
                end
                POP_ISSUE: begin
                    state <= POP_CAPTURE;
                end
                POP_CAPTURE: begin
                    rd_data  <= stk_pop;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STACK_GUARD_WATERMARK_EN
    // High-water mark of depth; err_clr rebases it to the depth being written this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max_depth <= '0;
        end else if (err_clr) begin
            max_depth <= depth_next;
        end else if (depth_next > max_depth) begin
            max_depth <= depth_next;
        end
    end
`endif

endmodule

// File: tb/tb_stack_guard.sv
// tb/tb_stack_guard.sv - self-checking bench for stack_guard against a queue-based reference model

`ifndef OP_PUSH_R
`define OP_PUSH_R 4'h1
`endif
`ifndef OP_POP_R
`define OP_POP_R 4'h2
`endif

module tb_stack_guard;

    localparam int         DW  = 14;
    localparam int         VOL = 12;
    localparam logic [3:0] NOP = 4'h0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_opcode = 4'h0;
    logic [DW-1:0] req_data = '0;
    logic [3:0]    stk_opcode;
    logic [DW-1:0] stk_push;
    logic [DW-1:0] stk_pop;
    logic          stk_reset;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [3:0]    depth;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          unf_err;
    logic          err_clr = 1'b0;
`ifdef STACK_GUARD_WATERMARK_EN
    logic [3:0]    max_depth;
`endif

    stack_guard dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opcode (req_opcode),
        .req_data   (req_data),
        .stk_opcode (stk_opcode),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_reset  (stk_reset),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err),
        .unf_err    (unf_err),
`ifdef STACK_GUARD_WATERMARK_EN
        .max_depth  (max_depth),
`endif
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // External operand stack: obeys its opcode, registered pop output, sync reset.
    logic [DW-1:0] smem[$];
    always @(posedge clk) begin
        if (stk_reset) begin
            smem.delete();
            stk_pop <= '0;
        end else if (stk_opcode == `OP_PUSH_R) begin
            smem.push_back(stk_push);
        end else if (stk_opcode == `OP_POP_R) begin
            if (smem.size() > 0) stk_pop <= smem.pop_back();
        end
    end

    // Reference model: contents the guard believes are on the stack, sticky flags, watermark.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    int            m_max;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".depth"}, 32'(depth), 32'(q.size()));
        check({tag, ".full"},  32'(full),  32'(q.size() == VOL));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".ovf"},   32'(ovf_err), 32'(m_ovf));
        check({tag, ".unf"},   32'(unf_err), 32'(m_unf));
`ifdef STACK_GUARD_WATERMARK_EN
        check({tag, ".max"},   32'(max_depth), 32'(m_max));
`endif
    endtask

    // One request cycle, driven and sampled at negedges; completes the pop handshake if one is started.
    task automatic send(input string tag, input bit v, input logic [3:0] op,
                        input logic [DW-1:0] d, input bit clr);
        logic [3:0]    exp_op;
        logic [DW-1:0] val;
        bit            popping;
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid  = v;
        req_opcode = op;
        req_data   = d;
        err_clr    = clr;
        @(negedge clk);
        req_valid  = 1'b0;
        err_clr    = 1'b0;
        req_opcode = 4'($urandom);
        req_data   = DW'($urandom);
        exp_op  = NOP;
        popping = 1'b0;
        val     = '0;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (v && op == `OP_PUSH_R) begin
            if (q.size() < VOL) begin
                q.push_back(d);
                exp_op = `OP_PUSH_R;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (v && op == `OP_POP_R) begin
            if (q.size() > 0) begin
                val     = q.pop_back();
                exp_op  = `OP_POP_R;
                popping = 1'b1;
            end else begin
                m_unf = 1'b1;
            end
        end
        if (clr) m_max = q.size();
        else if (q.size() > m_max) m_max = q.size();
        check({tag, ".op"}, 32'(stk_opcode), 32'(exp_op));
        if (exp_op == `OP_PUSH_R) check({tag, ".push"}, 32'(stk_push), 32'(d));
        check({tag, ".rdv"}, 32'(rd_valid), 32'd0);
        check_state(tag);
        if (popping) begin
            check({tag, ".ready_p0"}, 32'(req_ready), 32'd0);
            @(negedge clk);
            check({tag, ".op_p1"},    32'(stk_opcode), 32'(NOP));
            check({tag, ".ready_p1"}, 32'(req_ready), 32'd0);
            check({tag, ".rdv_p1"},   32'(rd_valid), 32'd0);
            @(negedge clk);
            check({tag, ".rdv_p2"},   32'(rd_valid), 32'd1);
            check({tag, ".rdata"},    32'(rd_data), 32'(val));
            check({tag, ".op_p2"},    32'(stk_opcode), 32'(NOP));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] rop;
        int         r;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.stk_reset", 32'(stk_reset), 32'd1);
        check("rst.ready",     32'(req_ready), 32'd0);
        check("rst.op",        32'(stk_opcode), 32'(NOP));
        check("rst.push",      32'(stk_push), 32'd0);
        check("rst.rdata",     32'(rd_data), 32'd0);
        check("rst.rdv",       32'(rd_valid), 32'd0);
        check_state("rst");

        // Release: stk_reset held across the first edge, requests held off meanwhile
        reset = 1'b1;
        #1;
        check("rel.stk_reset", 32'(stk_reset), 32'd1);
        check("rel.ready",     32'(req_ready), 32'd0);
        check("rel.empty",     32'(empty), 32'd1);
        @(negedge clk);
        check("rel1.stk_reset", 32'(stk_reset), 32'd0);
        check("rel1.ready",     32'(req_ready), 32'd1);
        check("rel1.op",        32'(stk_opcode), 32'(NOP));
        check_state("rel1");

        // Pop on empty, then idle cycles with no rd_valid, then a foreign opcode
        send("upop", 1'b1, `OP_POP_R, 14'h0123, 1'b0);
        send("idle0", 1'b0, `OP_POP_R, 14'h0, 1'b0);
        send("idle1", 1'b0, `OP_PUSH_R, 14'h1, 1'b0);
        send("op7",  1'b1, 4'h7, 14'h1555, 1'b0);
        send("uclr", 1'b0, 4'h0, 14'h0, 1'b1);

        // Back-to-back pushes then a pop returning the last one
        send("p0", 1'b1, `OP_PUSH_R, 14'h3FFF, 1'b0);
        send("p1", 1'b1, `OP_PUSH_R, 14'h0001, 1'b0);
        send("p2", 1'b1, `OP_PUSH_R, 14'h2AAA, 1'b0);
        send("pop2aaa", 1'b1, `OP_POP_R, 14'h0, 1'b0);

        // Fill to capacity, overflow, clear
        for (int i = 0; i < VOL - 2; i++) send("fill", 1'b1, `OP_PUSH_R, DW'($urandom), 1'b0);
        check("fill.full", 32'(full), 32'd1);
        send("ovf", 1'b1, `OP_PUSH_R, 14'h1234, 1'b0);
        send("oclr", 1'b0, 4'h0, 14'h0, 1'b1);

`ifdef STACK_GUARD_WATERMARK_EN
        do_reset();
        for (int i = 0; i < 5; i++) send("wm_push", 1'b1, `OP_PUSH_R, DW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) send("wm_pop", 1'b1, `OP_POP_R, 14'h0, 1'b0);
        send("wm_push1", 1'b1, `OP_PUSH_R, DW'($urandom), 1'b0);
        check("wm.max5", 32'(max_depth), 32'd5);
        send("wm_clr", 1'b0, 4'h0, 14'h0, 1'b1);
        check("wm.max3", 32'(max_depth), 32'd3);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                send("rnd_push", 1'b1, `OP_PUSH_R, DW'($urandom), ($urandom_range(0, 11) == 0));
            end else if (r <= 6) begin
                send("rnd_pop", 1'b1, `OP_POP_R, DW'($urandom), ($urandom_range(0, 11) == 0));
            end else if (r == 7) begin
                rop = 4'($urandom);
                while (rop == `OP_PUSH_R || rop == `OP_POP_R) rop = 4'($urandom);
                send("rnd_other", 1'b1, rop, DW'($urandom), ($urandom_range(0, 11) == 0));
            end else begin
                send("rnd_idle", 1'b0, 4'($urandom), DW'($urandom), ($urandom_range(0, 5) == 0));
            end
        end

        // Reset in the middle of a pop
        send("mp_push", 1'b1, `OP_PUSH_R, 14'h0777, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_opcode = `OP_POP_R;
        @(negedge clk);
        req_valid = 1'b0;
        check("mp.ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mp.depth",     32'(depth), 32'd0);
        check("mp.rdv",       32'(rd_valid), 32'd0);
        check("mp.stk_reset", 32'(stk_reset), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_max = 0;
        @(negedge clk);
        check("mp2.stk_reset", 32'(stk_reset), 32'd0);
        check("mp2.rdv",       32'(rd_valid), 32'd0);
        check_state("mp2");
        send("mp_after", 1'b1, `OP_PUSH_R, 14'h0042, 1'b0);
        send("mp_after_pop", 1'b1, `OP_POP_R, 14'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_guard.md
Name: stack_guard

Overview:
- Sequencer between the instruction decoder and the 12-entry operand stack.
- Accepts push/pop requests from the decoder and forwards only legal ones to the stack as opcodes and push data.
- Tracks stack depth, blocks overflow and underflow, and returns popped data to the register file with a valid strobe.
- Drives the stack's synchronous active-high reset from the core's asynchronous reset.

Parameters:
- DATA_W, 14, data word width; must match the stack.
- VOLUME, 12, stack capacity in entries.
- DEPTH_W, 4, depth counter width; must satisfy 2^DEPTH_W > VOLUME.
- NOP_OP, 4'h0, opcode driven to the stack when idle; must differ from `OP_PUSH_R and `OP_POP_R.

Ports:
- clk, in, 1, core clock; all state on the rising edge.
- reset, in, 1, asynchronous, active-low.
- req_valid, in, 1, decoder request strobe.
- req_ready, out, 1, high when a request can be accepted.
- req_opcode, in, 4, `OP_PUSH_R, `OP_POP_R, or any other value (ignored).
- req_data, in, DATA_W, value to push.
- stk_opcode, out, 4, opcode to the stack.
- stk_push, out, DATA_W, push data to the stack.
- stk_pop, in, DATA_W, stack's registered pop output.
- stk_reset, out, 1, synchronous active-high reset to the stack.
- rd_data, out, DATA_W, popped value to the register file.
- rd_valid, out, 1, one-cycle strobe qualifying rd_data.
- depth, out, DEPTH_W, current entry count.
- full, out, 1, depth == VOLUME.
- empty, out, 1, depth == 0.
- ovf_err, out, 1, sticky push-when-full flag.
- unf_err, out, 1, sticky pop-when-empty flag.
- err_clr, in, 1, synchronous clear of both sticky flags.

Behaviour:
- Reset (reset low, asynchronous) sets the following, with all outputs registered:
  - state=IDLE, depth=0, stk_opcode=NOP_OP, stk_push=0, rd_data=0, rd_valid=0, ovf_err=0, unf_err=0, stk_reset=1.
- stk_reset stays 1 for the first clock edge after reset deasserts, then drops to 0 permanently.
- Requests are held off (req_ready=0) while stk_reset=1.
- FSM states are IDLE, POP_ISSUE and POP_CAPTURE. req_ready=1 only in IDLE with stk_reset=0.
- A request is accepted on an edge where req_valid & req_ready.
- Accepted push, depth<VOLUME:
  - Next cycle: stk_opcode=`OP_PUSH_R, stk_push=req_data.
  - depth increments on the same edge.
  - FSM stays in IDLE, so back-to-back pushes run one per cycle.
- Accepted push, depth==VOLUME:
  - Nothing forwarded; stk_opcode=NOP_OP.
  - ovf_err set; depth unchanged.
- Accepted pop, depth>0:
  - Next cycle: stk_opcode=`OP_POP_R; depth decrements; FSM -> POP_ISSUE.
  - POP_ISSUE: stk_opcode=NOP_OP (stack is latching stk_pop at this edge); -> POP_CAPTURE.
  - POP_CAPTURE: rd_data<=stk_pop and rd_valid=1 for exactly one cycle after this edge; -> IDLE.
  - Latency: accept edge to rd_valid high = 3 edges. req_ready is low during POP_ISSUE and POP_CAPTURE.
- Accepted pop, depth==0:
  - Nothing forwarded; unf_err set; rd_valid stays 0; FSM stays in IDLE.
- Other opcodes: accepted and dropped, with no state change.
- stk_opcode returns to NOP_OP every cycle in which no legal push or pop is issued.
- err_clr: clears both flags on the next edge. If a new error occurs on the same edge, that error wins and its flag is set.
- req_valid low: no action; req_data and req_opcode are don't-care.
- full and empty are combinational decodes of the registered depth.
- Reset mid-pop (any state): returns to IDLE with rd_valid=0 and depth=0; the stack is re-reset through stk_reset.

Optional Feature:
- Macro: STACK_GUARD_WATERMARK_EN.
- Defined:
  - Adds output max_depth [DEPTH_W-1:0], reset to 0.
  - On any edge where the new depth exceeds max_depth, max_depth takes the new depth.
  - err_clr also clears max_depth to the current depth.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: after reset deasserts, stk_reset=1 for one edge, then 0. Meanwhile req_ready=0, depth=0, empty=1, stk_opcode=NOP_OP.
- Push 3FFF, 0001, 2AAA back-to-back: stk_opcode=`OP_PUSH_R on 3 consecutive cycles with matching stk_push; depth=3; req_ready stays 1.
- Pop after 3 pushes, with the stack model returning 2AAA:
  - rd_valid pulses once, 3 edges after accept, with rd_data=2AAA.
  - req_ready is low for 2 cycles; depth=2.
- Fill: 12 pushes give full=1. 13th push: stk_opcode stays NOP_OP, ovf_err=1, depth=12. Then err_clr clears ovf_err.
- Pop when empty right after reset: unf_err=1, rd_valid never asserts, depth=0. An opcode 4'h7 request causes no change.
- With STACK_GUARD_WATERMARK_EN: push 5, pop 3, push 1 gives max_depth=5. err_clr then sets max_depth=3.
